// File: rtl/enemy_pkg.sv
// +----------------------------------------------------------------------+
// | enemy_pkg - shared types and constants for the enemy formation block |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package enemy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENTER   = 2'd1,
        ST_SWAY    = 2'd2,
        ST_CLEARED = 2'd3
    } formation_state_e;

    typedef logic [9:0] coord_t;

    localparam int ScreenW = 640;
    localparam int ScreenH = 480;

    // Index width for addressing n enemies; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/enemy_alive_mask.sv
// +----------------------------------------------------------------------+
// | enemy_alive_mask - per-enemy alive register, kill decode, popcount   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module enemy_alive_mask
    import enemy_pkg::*;
#(
    parameter int EnemyCount = 40
) (
    input  logic                  frame_clk_i,
    input  logic                  reset_i,
    input  logic                  load_all_i,
    input  logic                  kill_en_i,
    input  logic [5:0]            kill_idx_i,
    output logic [EnemyCount-1:0] alive_o,
    output logic                  all_dead_next_o,
    output logic [6:0]            alive_count_o
);

    localparam int         IdxW     = idx_width(EnemyCount);
    localparam logic [6:0] CountLim = 7'(EnemyCount);

    logic [EnemyCount-1:0] alive_q, alive_d;
    logic                  kill_hit;
    logic [6:0]            count;

    // The range check matters when IdxW < 6: truncated high bits must not alias.
    assign kill_hit = kill_en_i && ({1'b0, kill_idx_i} < CountLim);

    always_comb begin
        alive_d = alive_q;
        if (load_all_i) begin
            alive_d = '1;
        end else if (kill_hit) begin
            for (int i = 0; i < EnemyCount; i++) begin
                if (kill_idx_i[IdxW-1:0] == IdxW'(i)) begin
                    alive_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge frame_clk_i or posedge reset_i) begin
        if (reset_i) begin
            alive_q <= '0;
        end else begin
            alive_q <= alive_d;
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < EnemyCount; i++) begin
            count = count + 7'(alive_q[i]);
        end
    end

    assign alive_o         = alive_q;
    assign all_dead_next_o = ~|alive_d;
    assign alive_count_o   = count;

endmodule

`default_nettype wire

// File: rtl/enemy_formation.sv
// +----------------------------------------------------------------------+
// | enemy_formation - wave FSM, base position and per-enemy coordinates  |
// | Rev 1.0  (optional breathing spacing: FORMATION_BREATHE_EN)          |
// +----------------------------------------------------------------------+
`default_nettype none

module enemy_formation
    import enemy_pkg::*;
#(
    parameter int EnemyCount = 40,
    parameter int Cols       = 10,
    parameter int Spacing    = 32,
    parameter int XMin       = 16,
    parameter int XMax       = 304,
    parameter int YStart     = 0,
    parameter int YHome      = 60
) (
    input  logic                           reset_i,
    input  logic                           frame_clk_i,
    input  logic                           start_i,
    input  logic [3:0]                     speed_i,
    input  logic                           kill_valid_i,
    input  logic [5:0]                     kill_idx_i,
    output coord_t [EnemyCount-1:0]        xpos_o,
    output coord_t [EnemyCount-1:0]        ypos_o,
    output logic   [EnemyCount-1:0]        alive_o,
    output logic   [6:0]                   alive_count_o,
    output logic   [1:0]                   state_o,
    output logic                           cleared_o
);

    localparam coord_t XMinC   = coord_t'(XMin);
    localparam coord_t XMaxC   = coord_t'(XMax);
    localparam coord_t YStartC = coord_t'(YStart);
    localparam coord_t YHomeC  = coord_t'(YHome);

    formation_state_e state_q, state_d;
    coord_t           base_x_q, base_x_d, base_y_q, base_y_d;
    logic             dir_left_q, dir_left_d;
    logic             cleared_q, cleared_d;
    logic             load_all, kill_en, all_dead_next;
    coord_t           speed, sum_x, sum_y, sp;

    assign load_all = start_i && (state_q == ST_IDLE || state_q == ST_CLEARED);
    assign kill_en  = kill_valid_i && (state_q == ST_ENTER || state_q == ST_SWAY);

    enemy_alive_mask #(
        .EnemyCount (EnemyCount)
    ) u_alive (
        .frame_clk_i     (frame_clk_i),
        .reset_i         (reset_i),
        .load_all_i      (load_all),
        .kill_en_i       (kill_en),
        .kill_idx_i      (kill_idx_i),
        .alive_o         (alive_o),
        .all_dead_next_o (all_dead_next),
        .alive_count_o   (alive_count_o)
    );

    assign speed = coord_t'(speed_i);
    assign sum_x = base_x_q + speed;
    assign sum_y = base_y_q + speed;

    always_comb begin
        state_d    = state_q;
        base_x_d   = base_x_q;
        base_y_d   = base_y_q;
        dir_left_d = dir_left_q;
        cleared_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_CLEARED: begin
                if (start_i) begin
                    base_x_d   = XMinC;
                    base_y_d   = YStartC;
                    dir_left_d = 1'b0;
                    state_d    = ST_ENTER;
                end
            end
            ST_ENTER: begin
                if (sum_y >= YHomeC) begin
                    base_y_d = YHomeC;
                    state_d  = ST_SWAY;
                end else begin
                    base_y_d = sum_y;
                end
            end
            ST_SWAY: begin
                if (!dir_left_q) begin
                    if (sum_x >= XMaxC) begin
                        base_x_d   = XMaxC;
                        dir_left_d = 1'b1;
                    end else begin
                        base_x_d = sum_x;
                    end
                end else if (base_x_q < XMinC + speed) begin
                    base_x_d   = XMinC;
                    dir_left_d = 1'b0;
                end else begin
                    base_x_d = base_x_q - speed;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Wiping out the wave overrides the ENTER->SWAY hop; motion still lands.
        if ((state_q == ST_ENTER || state_q == ST_SWAY) && all_dead_next) begin
            state_d   = ST_CLEARED;
            cleared_d = 1'b1;
        end
    end

    always_ff @(posedge frame_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            base_x_q   <= XMinC;
            base_y_q   <= YStartC;
            dir_left_q <= 1'b0;
            cleared_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_x_q   <= base_x_d;
            base_y_q   <= base_y_d;
            dir_left_q <= dir_left_d;
            cleared_q  <= cleared_d;
        end
    end

`ifdef FORMATION_BREATHE_EN
    logic [2:0] breathe_q, breathe_d, bcnt_q, bcnt_d;
    logic       breathe_down_q, breathe_down_d;

    // Triangle 0..7..0, one step every eight swaying frames.
    always_comb begin
        breathe_d      = breathe_q;
        bcnt_d         = bcnt_q;
        breathe_down_d = breathe_down_q;
        if (state_q == ST_SWAY) begin
            bcnt_d = bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) begin
                if (breathe_down_q) begin
                    breathe_d = breathe_q - 3'd1;
                    if (breathe_q == 3'd1) breathe_down_d = 1'b0;
                end else begin
                    breathe_d = breathe_q + 3'd1;
                    if (breathe_q == 3'd6) breathe_down_d = 1'b1;
                end
            end
        end
        if (load_all) begin
            breathe_d      = 3'd0;
            bcnt_d         = 3'd0;
            breathe_down_d = 1'b0;
        end
    end

    always_ff @(posedge frame_clk_i or posedge reset_i) begin
        if (reset_i) begin
            breathe_q      <= 3'd0;
            bcnt_q         <= 3'd0;
            breathe_down_q <= 1'b0;
        end else begin
            breathe_q      <= breathe_d;
            bcnt_q         <= bcnt_d;
            breathe_down_q <= breathe_down_d;
        end
    end

    assign sp = coord_t'(Spacing) + coord_t'(breathe_q);
`else
    assign sp = coord_t'(Spacing);
`endif

    for (genvar i = 0; i < EnemyCount; i++) begin : g_pos
        assign xpos_o[i] = base_x_q + sp * coord_t'(i % Cols);
        assign ypos_o[i] = base_y_q + sp * coord_t'(i / Cols);
    end

    assign state_o   = state_q;
    assign cleared_o = cleared_q;

endmodule

`default_nettype wire

// File: tb/tb_enemy_formation.sv
// +----------------------------------------------------------------------+
// | tb_enemy_formation - directed scoreboard bench for enemy_formation   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_enemy_formation;
    import enemy_pkg::*;

    localparam int N = 40;
    localparam logic [63:0] AllOnes = 64'h00FF_FFFF_FFFF;

    logic             reset_i, frame_clk_i, start_i, kill_valid_i;
    logic [3:0]       speed_i;
    logic [5:0]       kill_idx_i;
    coord_t [N-1:0]   xpos_o, ypos_o;
    logic [N-1:0]     alive_o;
    logic [6:0]       alive_count_o;
    logic [1:0]       state_o;
    logic             cleared_o;

    enemy_formation dut (
        .reset_i       (reset_i),
        .frame_clk_i   (frame_clk_i),
        .start_i       (start_i),
        .speed_i       (speed_i),
        .kill_valid_i  (kill_valid_i),
        .kill_idx_i    (kill_idx_i),
        .xpos_o        (xpos_o),
        .ypos_o        (ypos_o),
        .alive_o       (alive_o),
        .alive_count_o (alive_count_o),
        .state_o       (state_o),
        .cleared_o     (cleared_o)
    );

    initial frame_clk_i = 1'b0;
    always #5 frame_clk_i = ~frame_clk_i;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic expect_v(input string tag, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic observe(input logic [63:0] obs);
        exp_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty observed=%0h required=<entry>", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s observed=%0h required=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge frame_clk_i);
        #1;
    endtask

    task automatic kill(input int idx);
        kill_valid_i = 1'b1;
        kill_idx_i   = 6'(idx);
        tick();
        kill_valid_i = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1; start_i = 1'b0; speed_i = 4'd0;
        kill_valid_i = 1'b0; kill_idx_i = 6'd0;
        repeat (2) tick();

        expect_v("rst_state", 0); expect_v("rst_alive", 0); expect_v("rst_count", 0);
        expect_v("rst_cleared", 0); expect_v("rst_x0", 16); expect_v("rst_y0", 0);
        expect_v("rst_x11", 48); expect_v("rst_y11", 32);
        observe(64'(state_o)); observe(64'(alive_o)); observe(64'(alive_count_o));
        observe(64'(cleared_o)); observe(64'(xpos_o[0])); observe(64'(ypos_o[0]));
        observe(64'(xpos_o[11])); observe(64'(ypos_o[11]));

        reset_i = 1'b0;
        expect_v("idle_kill_alive", 0); expect_v("idle_kill_state", 0);
        kill(5);
        observe(64'(alive_o)); observe(64'(state_o));

        // Entry at speed 7: 0,7,...,56 then clamp to 60 on the ninth edge.
        start_i = 1'b1; speed_i = 4'd7;
        expect_v("start_state", 1); expect_v("start_alive", AllOnes); expect_v("start_y0", 0);
        tick();
        start_i = 1'b0;
        observe(64'(state_o)); observe(64'(alive_o)); observe(64'(ypos_o[0]));
        for (int k = 1; k <= 8; k++) begin
            expect_v("enter_y0", 64'(7 * k)); expect_v("enter_state", 1);
            tick();
            observe(64'(ypos_o[0])); observe(64'(state_o));
        end
        expect_v("home_y0", 60); expect_v("home_state", 2);
        expect_v("home_y39", 156); expect_v("home_x39", 304);
        tick();
        observe(64'(ypos_o[0])); observe(64'(state_o));
        observe(64'(ypos_o[39])); observe(64'(xpos_o[39]));

        // Walk right to base_x=300, then bounce off XMax.
        speed_i = 4'd4;
        repeat (71) tick();
        expect_v("sway_x300", 300); observe(64'(xpos_o[0]));
        speed_i = 4'd8;
        expect_v("bounce_xmax", 304); tick(); observe(64'(xpos_o[0]));
        expect_v("after_bounce", 296); tick(); observe(64'(xpos_o[0]));
        repeat (34) tick();
        expect_v("left_x24", 24); observe(64'(xpos_o[0]));
        speed_i = 4'd10;
        expect_v("clamp_xmin", 16); tick(); observe(64'(xpos_o[0]));
        expect_v("after_xmin", 26); tick(); observe(64'(xpos_o[0]));
        expect_v("sway_alive", AllOnes); observe(64'(alive_o));

        speed_i = 4'd0;
        kill(3);
        kill(3);
        expect_v("kill3_count", 39); expect_v("kill3_mask", AllOnes & ~64'h8);
        observe(64'(alive_count_o)); observe(64'(alive_o));
        kill(45);
        expect_v("kill45_count", 39); expect_v("kill45_mask", AllOnes & ~64'h8);
        observe(64'(alive_count_o)); observe(64'(alive_o));

        for (int i = 0; i < N - 1; i++) kill(i);
        expect_v("pre_clear_state", 2); expect_v("pre_clear_pulse", 0);
        observe(64'(state_o)); observe(64'(cleared_o));
        kill(N - 1);
        expect_v("clear_state", 3); expect_v("clear_pulse", 1); expect_v("clear_count", 0);
        observe(64'(state_o)); observe(64'(cleared_o)); observe(64'(alive_count_o));
        tick();
        expect_v("clear_pulse_gone", 0); expect_v("clear_hold", 3); expect_v("clear_x0", 26);
        observe(64'(cleared_o)); observe(64'(state_o)); observe(64'(xpos_o[0]));

        // Start and kill together in CLEARED: start wins.
        start_i = 1'b1; kill_valid_i = 1'b1; kill_idx_i = 6'd0;
        tick();
        start_i = 1'b0; kill_valid_i = 1'b0;
        expect_v("restart_state", 1); expect_v("restart_alive", AllOnes);
        expect_v("restart_y0", 0); expect_v("restart_x0", 16);
        observe(64'(state_o)); observe(64'(alive_o)); observe(64'(ypos_o[0])); observe(64'(xpos_o[0]));

        speed_i = 4'd15;
        repeat (4) tick();
        expect_v("fast_home_state", 2); expect_v("fast_home_y0", 60);
        observe(64'(state_o)); observe(64'(ypos_o[0]));
        speed_i = 4'd0;
        for (int i = 0; i < 12; i++) kill(i);
        expect_v("dead12_count", 28); observe(64'(alive_count_o));
        speed_i = 4'd3;
        repeat (2) tick();
        expect_v("pre_reset_x0", 22); observe(64'(xpos_o[0]));

        // Asynchronous reset: outputs must drop without a clock edge.
        reset_i = 1'b1;
        #1;
        expect_v("arst_state", 0); expect_v("arst_alive", 0); expect_v("arst_count", 0);
        expect_v("arst_x0", 16); expect_v("arst_y0", 0); expect_v("arst_cleared", 0);
        observe(64'(state_o)); observe(64'(alive_o)); observe(64'(alive_count_o));
        observe(64'(xpos_o[0])); observe(64'(ypos_o[0])); observe(64'(cleared_o));

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover observed=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
